cmd_point_arbiter: RTL and testbench

Shares one cmd_point (instruction address pointer) between NUM_REQ requesters, e.g. sequencer, interrupt unit and debug port.
- Round-robin arbitration over pending jump/skip requests.
- Drives cmd_point's opcode/addr_to for exactly one cycle per granted request.
- Waits for cmd_point ready, then returns a per-requester done pulse (with error on timeout or illegal opcode).

---
 rtl/cmd_point_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cmd_point_arbiter.sv | 143 ++++++++++++++
 tb/tb_cmd_point_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_point_pkg.sv
// Shared opcode and state definitions for the cmd_point arbiter and its requesters.
package cmd_point_pkg;

    localparam logic [2:0] NUL_CMD = 3'b000;
    localparam logic [2:0] JMP_CMD = 3'b001;
    localparam logic [2:0] SJF_CMD = 3'b010;
    localparam logic [2:0] SJB_CMD = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // NUL is legal: it completes without touching cmd_point.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == NUL_CMD) || (op == JMP_CMD) || (op == SJF_CMD) || (op == SJB_CMD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = last;
        any  = 1'b0;
        cand = last;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/cmd_point_arbiter.sv
// Shares one cmd_point between NUM_REQ requesters: round-robin grant, one-cycle issue,
// wait for cp_ready with timeout, then a done/err pulse back to the owner.
module cmd_point_arbiter
    import cmd_point_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [3*NUM_REQ-1:0]         req_opcode,
    input  logic [BUS_WIDTH*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         err,
    output logic                         busy,
    output logic [2:0]                   cp_opcode,
    output logic [BUS_WIDTH-1:0]         cp_addr_to,
    input  logic                         cp_ready
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_d, done_d;
    logic                 err_d, busy_d;
    logic [2:0]           cp_opcode_d;
    logic [BUS_WIDTH-1:0] cp_addr_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic [2:0]           win_op;
    logic [BUS_WIDTH-1:0] win_addr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        win_op   = NUL_CMD;
        win_addr = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_gnt[j]) begin
                win_op   = req_opcode[3*j +: 3];
                win_addr = req_addr[BUS_WIDTH*j +: BUS_WIDTH];
            end
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    // cp_addr_to doubles as the latched target address and is never cleared outside reset.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant;
        done_d      = '0;
        err_d       = 1'b0;
        busy_d      = busy;
        cp_opcode_d = NUL_CMD;
        cp_addr_d   = cp_addr_to;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    last_d  = arb_idx;
                    busy_d  = 1'b1;
                    if (is_legal_op(win_op) && (win_op != NUL_CMD)) begin
                        state_d     = ISSUE;
                        cp_opcode_d = win_op;
                        cp_addr_d   = win_addr;
                        cnt_d       = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = arb_gnt;
                        err_d   = !is_legal_op(win_op);
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(1);
            end
            WAIT: begin
                if (cp_ready) begin
                    state_d = DONE;
                    done_d  = grant;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = DONE;
                    done_d  = grant;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= IW'(NUM_REQ - 1);
            cnt_q      <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            cp_opcode  <= NUL_CMD;
            cp_addr_to <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant      <= grant_d;
            done       <= done_d;
            err        <= err_d;
            busy       <= busy_d;
            cp_opcode  <= cp_opcode_d;
            cp_addr_to <= cp_addr_d;
        end
    end

endmodule

// File: tb/tb_cmd_point_arbiter.sv
// Directed bench for cmd_point_arbiter with a scoreboard of expected completions.
module tb_cmd_point_arbiter;
    import cmd_point_pkg::*;

    localparam int BW = 32;
    localparam int NR = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [3*NR-1:0]   req_opcode = '0;
    logic [BW*NR-1:0]  req_addr = '0;
    logic              cp_ready = 1'b0;
    logic [NR-1:0]     grant, done;
    logic              err, busy;
    logic [2:0]        cp_opcode;
    logic [BW-1:0]     cp_addr_to;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [NR-1:0] grant;
        logic          err;
        int            issue_cnt;
        logic [2:0]    op;
        logic [BW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];

    int            issue_cnt = 0;
    logic [2:0]    issue_op = '0;
    logic [BW-1:0] issue_addr = '0;

    always #5 clk = ~clk;

    cmd_point_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .cp_opcode  (cp_opcode),
        .cp_addr_to (cp_addr_to),
        .cp_ready   (cp_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [BW-1:0] a);
        req[i] = 1'b1;
        req_opcode[3*i +: 3] = op;
        req_addr[BW*i +: BW] = a;
    endtask

    task automatic push_exp(input logic [NR-1:0] g, input logic e, input int n,
                            input logic [2:0] op, input logic [BW-1:0] a);
        exp_t x;
        x.grant = g;
        x.err = e;
        x.issue_cnt = n;
        x.op = op;
        x.addr = a;
        sb_q.push_back(x);
    endtask

    // Observes every issue cycle and retires one scoreboard entry per done pulse.
    always @(negedge clk) begin
        if (reset) begin
            issue_cnt = 0;
        end else begin
            if (cp_opcode !== NUL_CMD) begin
                issue_cnt++;
                issue_op = cp_opcode;
                issue_addr = cp_addr_to;
            end
            if (done !== '0) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_done", 64'(done), 64'(e.grant));
                    chk("sb_grant", 64'(grant), 64'(e.grant));
                    chk("sb_err", 64'(err), 64'(e.err));
                    chk("sb_issue_cnt", 64'(issue_cnt), 64'(e.issue_cnt));
                    if (e.issue_cnt != 0) begin
                        chk("sb_issue_op", 64'(issue_op), 64'(e.op));
                        chk("sb_issue_addr", 64'(issue_addr), 64'(e.addr));
                    end
                end
                issue_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR-1:0] rr_exp [5];
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cp_opcode", 64'(cp_opcode), 64'(NUL_CMD));
        chk("rst_cp_addr", 64'(cp_addr_to), 64'(0));

        // Single JMP, ready three cycles after issue
        set_req(0, JMP_CMD, 32'h0000_1234);
        push_exp(4'b0001, 1'b0, 1, JMP_CMD, 32'h0000_1234);
        step();
        chk("t1_grant", 64'(grant), 64'(4'b0001));
        chk("t1_issue_op", 64'(cp_opcode), 64'(JMP_CMD));
        chk("t1_issue_addr", 64'(cp_addr_to), 64'(32'h0000_1234));
        chk("t1_busy", 64'(busy), 64'(1));
        step();
        chk("t1_wait_op", 64'(cp_opcode), 64'(NUL_CMD));
        chk("t1_wait_addr", 64'(cp_addr_to), 64'(32'h0000_1234));
        step();
        step();
        cp_ready = 1'b1;
        chk("t1_no_early_done", 64'(done), 64'(0));
        step();
        chk("t1_done", 64'(done), 64'(4'b0001));
        chk("t1_err", 64'(err), 64'(0));
        req = '0;
        cp_ready = 1'b0;
        step();
        chk("t1_idle_busy", 64'(busy), 64'(0));
        chk("t1_idle_grant", 64'(grant), 64'(0));
        chk("t1_idle_done", 64'(done), 64'(0));
        chk("t1_addr_hold", 64'(cp_addr_to), 64'(32'h0000_1234));

        // All four requesting, ready tied high: strict rotation, 4 cycles each
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, SJF_CMD, 32'd2);
        cp_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(rr_exp[k], 1'b0, 1, SJF_CMD, 32'd2);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", 64'(grant), 64'(rr_exp[k]));
            chk("t2_issue_op", 64'(cp_opcode), 64'(SJF_CMD));
            step();
            step();
            chk("t2_done", 64'(done), 64'(rr_exp[k]));
            if (k == 4) req = '0;
            step();
            chk("t2_idle_grant", 64'(grant), 64'(0));
        end

        // Illegal opcode on requester 2
        set_req(2, 3'b011, 32'h77);
        push_exp(4'b0100, 1'b1, 0, NUL_CMD, 32'h0);
        step();
        chk("t3_done", 64'(done), 64'(4'b0100));
        chk("t3_err", 64'(err), 64'(1));
        chk("t3_no_issue", 64'(cp_opcode), 64'(NUL_CMD));
        chk("t3_grant", 64'(grant), 64'(4'b0100));
        req = '0;
        step();
        chk("t3_done_clear", 64'(done), 64'(0));
        chk("t3_busy", 64'(busy), 64'(0));

        // Timeout after TO wait cycles, then a normal transaction
        cp_ready = 1'b0;
        set_req(3, JMP_CMD, 32'hABCD);
        push_exp(4'b1000, 1'b1, 1, JMP_CMD, 32'hABCD);
        step();
        chk("t4_grant", 64'(grant), 64'(4'b1000));
        for (int w = 1; w <= TO; w++) begin
            step();
            chk("t4_wait_no_done", 64'(done), 64'(0));
        end
        step();
        chk("t4_done", 64'(done), 64'(4'b1000));
        chk("t4_err", 64'(err), 64'(1));
        req = '0;
        step();
        set_req(0, JMP_CMD, 32'd5);
        cp_ready = 1'b1;
        push_exp(4'b0001, 1'b0, 1, JMP_CMD, 32'd5);
        step();
        chk("t4_next_grant", 64'(grant), 64'(4'b0001));
        step();
        step();
        chk("t4_next_done", 64'(done), 64'(4'b0001));
        chk("t4_next_err", 64'(err), 64'(0));
        req = '0;
        cp_ready = 1'b0;
        step();

        // Reset during WAIT aborts silently; requester 0 regains top priority
        set_req(0, JMP_CMD, 32'h10);
        set_req(1, JMP_CMD, 32'h20);
        step();
        chk("t5_grant_before", 64'(grant), 64'(4'b0010));
        step();
        reset = 1'b1;
        step();
        chk("t5_rst_grant", 64'(grant), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_op", 64'(cp_opcode), 64'(NUL_CMD));
        chk("t5_rst_done", 64'(done), 64'(0));
        reset = 1'b0;
        cp_ready = 1'b1;
        push_exp(4'b0001, 1'b0, 1, JMP_CMD, 32'h10);
        push_exp(4'b0010, 1'b0, 1, JMP_CMD, 32'h20);
        step();
        chk("t5_prio_grant", 64'(grant), 64'(4'b0001));
        step();
        step();
        chk("t5_done0", 64'(done), 64'(4'b0001));
        req[0] = 1'b0;
        step();
        step();
        chk("t5_grant1", 64'(grant), 64'(4'b0010));
        step();
        step();
        chk("t5_done1", 64'(done), 64'(4'b0010));
        req = '0;
        cp_ready = 1'b0;
        step();

        // Inputs changed and req dropped after grant are ignored
        set_req(1, SJB_CMD, 32'd2);
        push_exp(4'b0010, 1'b0, 1, SJB_CMD, 32'd2);
        step();
        chk("t6_grant", 64'(grant), 64'(4'b0010));
        chk("t6_issue_op", 64'(cp_opcode), 64'(SJB_CMD));
        chk("t6_issue_addr", 64'(cp_addr_to), 64'(32'd2));
        req = '0;
        req_opcode[5:3] = JMP_CMD;
        req_addr[63:32] = 32'hFFFF;
        step();
        chk("t6_wait_addr", 64'(cp_addr_to), 64'(32'd2));
        cp_ready = 1'b1;
        step();
        chk("t6_done", 64'(done), 64'(4'b0010));
        cp_ready = 1'b0;
        step();
        step();
        chk("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
